game_ctrl: RTL and testbench
============================

// Module: game_ctrl
//
// PURPOSE
//   Top-level sequencer for the stacking game.
//   - Runs the game state machine: idle, spawn, fall, paused, over.
//   - Gates the falling item through play_en and restarts it through spawn.
//   - Decides catch or miss each time the falling item reaches the top of the stack.
//   - Keeps the score and lives that feed the seven-segment display and draw.
//   - Sits in the game top, between the button inputs and falling_item / stack / draw.
//
// PARAMETERS
//   FLOOR_Y     440  y pixel of the stack base (top edge of block 0)
//   BLOCK_H     8    pixel height of one stacked block
//   ITEM_H      16   pixel height of the falling item
//   CATCH_W     24   max |fall_x - stack_x| that counts as a catch
//   MAX_HEIGHT  40   stack height that ends the game (tower complete)
//   LIVES       3    lives loaded at game start (1..3)
//
// PORTS
//   clk           in   1   system clock
//   rst           in   1   synchronous, active-high reset
//   start_btn     in   1   debounced start level; rising edge starts or restarts a game
//   pause_btn     in   1   debounced pause level; rising edge toggles pause
//   fall_tick     in   1   one-clk pulse per falling-item step (fall_clk edge)
//   fall_x        in   10  falling item x
//   fall_y        in   10  falling item top y
//   stack_x       in   10  stack x
//   stack_height  in   10  blocks currently on the stack
//   play_en       out  1   1 = falling item may move
//   spawn         out  1   1-cycle pulse: reload item at top
//   catch         out  1   1-cycle pulse: item landed on stack (stack grows)
//   miss          out  1   1-cycle pulse: item missed
//   score         out  16  catches so far (format set by macro below)
//   lives         out  2   lives remaining
//   game_over     out  1   high while in OVER
//   state         out  3   IDLE=0 SPAWN=1 FALL=2 PAUSED=3 OVER=4
//
// BEHAVIOUR
//   - Reset values: state=IDLE, lives=LIVES, score=0, all other outputs 0.
//     Button edge registers are cleared to 0.
//   - Edge detect: edge = btn & ~btn_q, using the btn_q register.
//     A button held high through reset gives no edge.
//   - All outputs are registered.
//   - IDLE/OVER: a start edge clears score, reloads lives, and moves to SPAWN next cycle.
//   - SPAWN: lasts exactly one cycle. spawn=1, play_en=0. Next state is FALL.
//   - FALL: play_en=1. A fall_tick evaluates the landing check in that cycle:
//     - catch_y = FLOOR_Y - stack_height*BLOCK_H in 11 bits, clamped at 0.
//     - landed = (fall_y + ITEM_H) >= catch_y, computed in 11 bits.
//     - hit = |fall_x - stack_x| <= CATCH_W, using an 11-bit signed difference.
//     - Not landed: stay in FALL.
//     - Landed and hit: catch=1 next cycle and score+1, saturating at 9999.
//       If stack_height+1 >= MAX_HEIGHT, go to OVER, else go to SPAWN.
//     - Landed and not hit: miss=1 next cycle and lives-1.
//       If lives becomes 0, go to OVER, else go to SPAWN.
//   - Latency: tick to catch/miss pulse is 1 cycle. Tick to the next spawn pulse is 2 cycles.
//   - Pause: an edge in FALL goes to PAUSED (play_en=0). An edge in PAUSED returns to FALL.
//     Pause edges are ignored in IDLE, SPAWN and OVER.
//   - fall_tick is ignored in every state except FALL.
//   - A pause edge and a fall_tick in the same FALL cycle: the tick is processed and the pause edge is dropped.
//   - A start edge in SPAWN, FALL or PAUSED restarts the game: score=0, lives=LIVES, go to SPAWN.
//   - A start edge and a fall_tick in the same cycle: start wins and no catch/miss pulse is issued.
//   - lives never underflows. OVER is entered on the transition to 0.
//
// CONFIGURATION
//   SCORE_BCD_EN defined:
//     - score is 4 packed BCD digits [15:12]..[3:0].
//     - Increment uses per-digit carry; it saturates at 16'h9999.
//   SCORE_BCD_EN undefined:
//     - score[13:0] is binary, score[15:14]=0.
//     - It saturates at 14'd9999.
//
// TESTING
//   1. Reset, then start edge at cycle N:
//      state=SPAWN and spawn=1 at N+1; state=FALL and play_en=1 at N+2; lives=3, score=0.
//   2. stack_height=0, fall_y=424, fall_x=300, stack_x=310, tick:
//      catch=1 for 1 cycle, score=1, then spawn pulse 2 cycles after the tick.
//   3. fall_x=100, stack_x=300, fall_y=424, three landing ticks:
//      lives=2,1,0; miss pulses each time; game_over=1 and state=4 after the third.
//   4. Pause edge in FALL: play_en=0 and 10 ticks give no pulses.
//      Second edge: play_en=1 again. Pause edge together with a landing tick: catch pulse issued, state not PAUSED.
//   5. Preload score=9999, catch: score unchanged (16'h9999 with SCORE_BCD_EN, 14'd9999 without).
//      A catch at 0x0099 (BCD) gives 0x0100.
//   6. stack_height=39, landing hit: catch=1 and next state OVER.
//      Then a start edge: score=0, lives=3, state=SPAWN.

Source files
------------

// File: rtl/game_ctrl.sv
// Stacking-game sequencer: game FSM, catch/miss decision, score and lives.
// Define SCORE_BCD_EN to keep the score as four packed BCD digits instead of binary.
module game_ctrl #(
  parameter int FLOOR_Y    = 440,
  parameter int BLOCK_H    = 8,
  parameter int ITEM_H     = 16,
  parameter int CATCH_W    = 24,
  parameter int MAX_HEIGHT = 40,
  parameter int LIVES      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        fall_tick,
  input  logic [9:0]  fall_x,
  input  logic [9:0]  fall_y,
  input  logic [9:0]  stack_x,
  input  logic [9:0]  stack_height,
  output logic        play_en,
  output logic        spawn,
  output logic        catch,
  output logic        miss,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic [2:0]  state
);

  // S_LAND is the one-cycle gap between a landing and the next spawn; it reports as FALL.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPAWN  = 3'd1,
    S_FALL   = 3'd2,
    S_PAUSED = 3'd3,
    S_OVER   = 3'd4,
    S_LAND   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic        catch_q, catch_d;
  logic        miss_q, miss_d;
  logic        spawn_q, spawn_d;
  logic        play_en_q, play_en_d;
  logic        game_over_q, game_over_d;
  logic [2:0]  state_out_q, state_out_d;

  logic [1:0]  btn_w, btn_q, arm_q;
  logic        start_rise, pause_rise;

  logic [13:0] drop_px;
  logic [10:0] catch_y, item_bot, dx, adx;
  logic        landed, hit, tower_done;

  // arm_q blocks the edge of a button that was already held when reset ended.
  assign btn_w      = {pause_btn, start_btn};
  assign start_rise = btn_w[0] & ~btn_q[0] & arm_q[0];
  assign pause_rise = btn_w[1] & ~btn_q[1] & arm_q[1];

  assign drop_px    = 14'(stack_height) * 14'(BLOCK_H);
  assign catch_y    = (drop_px >= 14'(FLOOR_Y)) ? 11'd0 : 11'(14'(FLOOR_Y) - drop_px);
  assign item_bot   = {1'b0, fall_y} + 11'(ITEM_H);
  assign landed     = (item_bot >= catch_y);
  assign dx         = {1'b0, fall_x} - {1'b0, stack_x};
  assign adx        = dx[10] ? (~dx + 11'd1) : dx;
  assign hit        = (adx <= 11'(CATCH_W));
  assign tower_done = (({1'b0, stack_height} + 11'd1) >= 11'(MAX_HEIGHT));

`ifdef SCORE_BCD_EN
  function automatic logic [15:0] score_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = 1'b1;
    if (s != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (s[4*i +: 4] >= 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = s[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction
`else
  function automatic logic [15:0] score_inc(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    if (s[13:0] < 14'd9999) begin
      r = {2'b00, s[13:0] + 14'd1};
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    catch_d = 1'b0;
    miss_d  = 1'b0;

    if (start_rise) begin
      // A start edge always wins, even over a landing tick in the same cycle.
      score_d = 16'd0;
      lives_d = 2'(LIVES);
      state_d = S_SPAWN;
    end else begin
      case (state_q)
        S_SPAWN: state_d = S_FALL;
        S_LAND:  state_d = S_SPAWN;
        S_FALL: begin
          if (fall_tick) begin
            if (landed) begin
              if (hit) begin
                catch_d = 1'b1;
                score_d = score_inc(score_q);
                state_d = tower_done ? S_OVER : S_LAND;
              end else begin
                miss_d  = 1'b1;
                lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                state_d = (lives_q <= 2'd1) ? S_OVER : S_LAND;
              end
            end
          end else if (pause_rise) begin
            state_d = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (pause_rise) begin
            state_d = S_FALL;
          end
        end
        S_IDLE, S_OVER: state_d = state_q;
        default:        state_d = S_IDLE;
      endcase
    end

    spawn_d     = (state_d == S_SPAWN);
    play_en_d   = (state_d == S_FALL);
    game_over_d = (state_d == S_OVER);
    state_out_d = (state_d == S_LAND) ? 3'd2 : state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      score_q     <= 16'd0;
      lives_q     <= 2'(LIVES);
      catch_q     <= 1'b0;
      miss_q      <= 1'b0;
      spawn_q     <= 1'b0;
      play_en_q   <= 1'b0;
      game_over_q <= 1'b0;
      state_out_q <= 3'd0;
      btn_q       <= 2'b00;
      arm_q       <= ~btn_w;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      catch_q     <= catch_d;
      miss_q      <= miss_d;
      spawn_q     <= spawn_d;
      play_en_q   <= play_en_d;
      game_over_q <= game_over_d;
      state_out_q <= state_out_d;
      btn_q       <= btn_w;
      arm_q       <= arm_q | ~btn_w;
    end
  end

  assign play_en   = play_en_q;
  assign spawn     = spawn_q;
  assign catch     = catch_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;
  assign state     = state_out_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus random play, checked every cycle against a rule-level model.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst, start_btn, pause_btn, fall_tick;
  logic [9:0]  fall_x, fall_y, stack_x, stack_height;
  logic        play_en, spawn, catch, miss, game_over;
  logic [15:0] score;
  logic [1:0]  lives;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  // Model: visible state code, "landing being resolved" flag, score as a plain count.
  int   m_state, m_score, m_lives;
  bit   m_land, m_catch, m_miss;
  logic m_prev_start, m_prev_pause;

  game_ctrl dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
    .fall_tick(fall_tick), .fall_x(fall_x), .fall_y(fall_y), .stack_x(stack_x),
    .stack_height(stack_height), .play_en(play_en), .spawn(spawn), .catch(catch),
    .miss(miss), .score(score), .lives(lives), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_score(input int n);
`ifdef SCORE_BCD_EN
    return 16'(((n / 1000) % 10) << 12 | ((n / 100) % 10) << 8 | ((n / 10) % 10) << 4 | (n % 10));
`else
    return 16'(n);
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit se, pe;
    int cy, d;
    if (rst) begin
      m_state = 0; m_land = 0; m_score = 0; m_lives = 3;
      m_catch = 0; m_miss = 0;
      m_prev_start = start_btn; m_prev_pause = pause_btn;
      return;
    end
    se = start_btn && !m_prev_start;
    pe = pause_btn && !m_prev_pause;
    m_prev_start = start_btn;
    m_prev_pause = pause_btn;
    m_catch = 0;
    m_miss  = 0;
    if (se) begin
      m_score = 0; m_lives = 3; m_state = 1; m_land = 0;
    end else if (m_land) begin
      m_land = 0; m_state = 1;
    end else if (m_state == 1) begin
      m_state = 2;
    end else if (m_state == 2) begin
      if (fall_tick) begin
        cy = 440 - int'(stack_height) * 8;
        if (cy < 0) cy = 0;
        d = int'(fall_x) - int'(stack_x);
        if (d < 0) d = -d;
        if (int'(fall_y) + 16 >= cy) begin
          if (d <= 24) begin
            m_catch = 1;
            if (m_score < 9999) m_score++;
            if (int'(stack_height) + 1 >= 40) m_state = 4; else m_land = 1;
          end else begin
            m_miss = 1;
            m_lives--;
            if (m_lives == 0) m_state = 4; else m_land = 1;
          end
        end
      end else if (pe) begin
        m_state = 3;
      end
    end else if (m_state == 3) begin
      if (pe) m_state = 2;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("state", 16'(state), 16'(m_state));
    chk("play_en", 16'(play_en), 16'(m_state == 2 && !m_land));
    chk("spawn", 16'(spawn), 16'(m_state == 1));
    chk("catch", 16'(catch), 16'(m_catch));
    chk("miss", 16'(miss), 16'(m_miss));
    chk("score", score, exp_score(m_score));
    chk("lives", 16'(lives), 16'(m_lives));
    chk("game_over", 16'(game_over), 16'(m_state == 4));
  endtask

  task automatic press_start();
    start_btn = 1'b1; cycle();
    start_btn = 1'b0; cycle();
  endtask

  initial begin
    int off, f;
    rst = 1'b1; start_btn = 1'b1; pause_btn = 1'b0; fall_tick = 1'b0;
    fall_x = 10'd0; fall_y = 10'd0; stack_x = 10'd0; stack_height = 10'd0;
    repeat (3) cycle();
    chk("rst_lives", 16'(lives), 16'd3);
    chk("rst_state", 16'(state), 16'd0);
    // Start held through reset must not start a game.
    rst = 1'b0;
    repeat (3) cycle();
    chk("held_start_idle", 16'(state), 16'd0);
    start_btn = 1'b0; cycle();

    // Start: SPAWN one cycle later, FALL the cycle after.
    start_btn = 1'b1; cycle();
    chk("t1_spawn", 16'(spawn), 16'd1);
    chk("t1_state_spawn", 16'(state), 16'd1);
    start_btn = 1'b0; cycle();
    chk("t1_play_en", 16'(play_en), 16'd1);
    chk("t1_state_fall", 16'(state), 16'd2);

    // Catch: pulse after 1 cycle, spawn after 2.
    fall_x = 10'd300; stack_x = 10'd310; fall_y = 10'd424;
    fall_tick = 1'b1; cycle(); fall_tick = 1'b0;
    chk("t2_catch", 16'(catch), 16'd1);
    chk("t2_score", score, exp_score(1));
    cycle();
    chk("t2_catch_clear", 16'(catch), 16'd0);
    chk("t2_spawn", 16'(spawn), 16'd1);
    cycle();

    // One pixel short of the stack top: not landed.
    fall_y = 10'd423;
    fall_tick = 1'b1; cycle(); fall_tick = 1'b0;
    chk("not_landed_state", 16'(state), 16'd2);
    fall_y = 10'd424;

    // Three misses end the game.
    fall_x = 10'd100; stack_x = 10'd300;
    for (int i = 0; i < 3; i++) begin
      fall_tick = 1'b1; cycle(); fall_tick = 1'b0;
      chk("t3_miss", 16'(miss), 16'd1);
      chk("t3_lives", 16'(lives), 16'(2 - i));
      cycle(); cycle();
    end
    chk("t3_game_over", 16'(game_over), 16'd1);
    chk("t3_state", 16'(state), 16'd4);
    fall_tick = 1'b1; repeat (3) cycle(); fall_tick = 1'b0;

    // Pause blocks ticks; pause together with a tick keeps the tick.
    press_start();
    fall_x = 10'd300; stack_x = 10'd310;
    pause_btn = 1'b1; cycle();
    chk("t4_paused_play_en", 16'(play_en), 16'd0);
    fall_tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t4_no_catch", 16'(catch), 16'd0);
    end
    fall_tick = 1'b0; pause_btn = 1'b0; cycle();
    pause_btn = 1'b1; cycle();
    chk("t4_resume_play_en", 16'(play_en), 16'd1);
    pause_btn = 1'b0; cycle();
    pause_btn = 1'b1; fall_tick = 1'b1; cycle();
    pause_btn = 1'b0; fall_tick = 1'b0;
    chk("t4_tick_wins", 16'(catch), 16'd1);
    chk("t4_not_paused", 16'(state), 16'd2);
    cycle(); cycle();

    // Start and landing tick together: restart, no pulse.
    start_btn = 1'b1; fall_tick = 1'b1; cycle();
    start_btn = 1'b0; fall_tick = 1'b0;
    chk("start_wins_catch", 16'(catch), 16'd0);
    chk("start_wins_state", 16'(state), 16'd1);
    cycle();

    // Random play.
    for (int i = 0; i < 800; i++) begin
      start_btn = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) pause_btn = ~pause_btn;
      fall_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) stack_height = 10'($urandom_range(0, 70));
      stack_x = 10'($urandom_range(0, 1023));
      off = int'($urandom_range(0, 80)) - 40;
      f = int'(stack_x) + off;
      if (f < 0) f = 0;
      if (f > 1023) f = 1023;
      fall_x = 10'(f);
      fall_y = 10'($urandom_range(0, 1023));
      cycle();
    end
    start_btn = 1'b0; pause_btn = 1'b0; fall_tick = 1'b0; cycle();

    // Tower complete at height 39, then restart.
    stack_height = 10'd39; fall_x = 10'd500; stack_x = 10'd520; fall_y = 10'd200;
    press_start();
    fall_tick = 1'b1; cycle(); fall_tick = 1'b0;
    chk("t6_catch", 16'(catch), 16'd1);
    chk("t6_over", 16'(state), 16'd4);
    press_start();
    chk("t6_restart_score", score, 16'd0);
    chk("t6_restart_lives", 16'(lives), 16'd3);

    // Score saturation at 9999.
    stack_height = 10'd0; fall_x = 10'd300; stack_x = 10'd300; fall_y = 10'd424;
    for (int i = 1; i <= 10002; i++) begin
      fall_tick = 1'b1; cycle(); fall_tick = 1'b0;
      if (i == 100) chk("t5_carry_100", score, exp_score(100));
      cycle(); cycle();
    end
    chk("t5_saturated", score, exp_score(9999));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
